// File: rtl/reg_if_arbiter.sv
// -----------------------------------------------------------------------------
// reg_if_arbiter
//
// Shares one register-file interface between two requesters:
//   requester 0 = MDIO slave backend, requester 1 = on-chip host/debug master.
// Round-robin grant, a single outstanding transaction, the response routed back
// to the granted requester, and a watchdog that completes a transaction the
// register file never acknowledges.
//
// Parameters
//   TIMEOUT_CYC    cycles spent in BUSY before forced completion (0 = off)
//   TIMEOUT_RDATA  read data returned to the requester on a timeout
//
// Ports
//   clk_25m, rst                   25 MHz clock, synchronous active-high reset
//   mX_valid/we/addr/wdata         requester X request (held until mX_ready)
//   mX_rdata, mX_ready             requester X read data and completion pulse
//   reg_if_valid/we/addr/wdata     request towards the register file
//   reg_if_rdata, reg_if_ready     register file response (rdata valid with ready)
//   timeout_pulse                  one-cycle pulse when the watchdog fires
//   grant_id                       requester owning the current/last transaction
// -----------------------------------------------------------------------------
module reg_if_arbiter #(
  parameter int unsigned TIMEOUT_CYC   = 255,
  parameter logic [15:0] TIMEOUT_RDATA = 16'hDEAD
) (
  input  logic        clk_25m,
  input  logic        rst,

  input  logic        m0_valid,
  input  logic        m0_we,
  input  logic [20:0] m0_addr,
  input  logic [15:0] m0_wdata,
  output logic [15:0] m0_rdata,
  output logic        m0_ready,

  input  logic        m1_valid,
  input  logic        m1_we,
  input  logic [20:0] m1_addr,
  input  logic [15:0] m1_wdata,
  output logic [15:0] m1_rdata,
  output logic        m1_ready,

  output logic        reg_if_valid,
  output logic        reg_if_we,
  output logic [20:0] reg_if_addr,
  output logic [15:0] reg_if_wdata,
  input  logic [15:0] reg_if_rdata,
  input  logic        reg_if_ready,

  output logic        timeout_pulse,
  output logic        grant_id
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  // Counter value seen in the last BUSY cycle before the watchdog fires.
  localparam logic [7:0] WD_LAST = 8'(TIMEOUT_CYC - 1);
  localparam bit         WD_EN   = (TIMEOUT_CYC != 0);

  state_t      state;
  logic [7:0]  wd_cnt;
  logic        pick;
  logic        wd_fire;
  logic        done;
  logic [15:0] rsp_data;

  // grant_id doubles as the last-grant record: it only changes on a grant, so
  // with both requesters valid the one that did not win last time is picked.
  assign pick     = (m0_valid && m1_valid) ? ~grant_id : m1_valid;
  assign wd_fire  = WD_EN && (wd_cnt == WD_LAST);
  // A real acknowledge always beats a simultaneous watchdog expiry.
  assign done     = reg_if_ready || wd_fire;
  assign rsp_data = reg_if_ready ? reg_if_rdata : TIMEOUT_RDATA;

  // NOTE: every register here is updated with <= so all reads within the block
  // see the values from before the clock edge, exactly like the flops do.
  always_ff @(posedge clk_25m) begin
    if (rst) begin
      state         <= IDLE;
      wd_cnt        <= '0;
      reg_if_valid  <= 1'b0;
      reg_if_we     <= 1'b0;
      reg_if_addr   <= '0;
      reg_if_wdata  <= '0;
      m0_rdata      <= '0;
      m1_rdata      <= '0;
      m0_ready      <= 1'b0;
      m1_ready      <= 1'b0;
      timeout_pulse <= 1'b0;
      grant_id      <= 1'b1;  // requester 0 wins the first contended grant
    end else begin
      // Single-cycle pulses default low and are raised only where needed.
      m0_ready      <= 1'b0;
      m1_ready      <= 1'b0;
      timeout_pulse <= 1'b0;

      case (state)
        IDLE: begin
          if (m0_valid || m1_valid) begin
            grant_id     <= pick;
            reg_if_we    <= pick ? m1_we    : m0_we;
            reg_if_addr  <= pick ? m1_addr  : m0_addr;
            reg_if_wdata <= pick ? m1_wdata : m0_wdata;
            reg_if_valid <= 1'b1;
            wd_cnt       <= '0;
            state        <= BUSY;
          end
        end

        BUSY: begin
          if (done) begin
            reg_if_valid  <= 1'b0;
            timeout_pulse <= !reg_if_ready;
            if (grant_id) begin
              m1_rdata <= rsp_data;
              m1_ready <= 1'b1;
            end else begin
              m0_rdata <= rsp_data;
              m0_ready <= 1'b1;
            end
            state <= RESP;
          end else if (wd_cnt != 8'hFF) begin
            wd_cnt <= wd_cnt + 8'd1;
          end
        end

        // mX_ready is high for this one cycle; the requester drops valid after it.
        RESP: state <= IDLE;

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_if_arbiter.sv
`timescale 1ns/1ps
module tb_reg_if_arbiter;

  localparam int          TO    = 8;
  localparam logic [15:0] TO_RD = 16'hDEAD;

  logic        clk_25m = 1'b0;
  logic        rst = 1'b1;
  logic        m0_valid = 1'b0, m0_we = 1'b0;
  logic [20:0] m0_addr = '0;
  logic [15:0] m0_wdata = '0;
  logic [15:0] m0_rdata;
  logic        m0_ready;
  logic        m1_valid = 1'b0, m1_we = 1'b0;
  logic [20:0] m1_addr = '0;
  logic [15:0] m1_wdata = '0;
  logic [15:0] m1_rdata;
  logic        m1_ready;
  logic        reg_if_valid, reg_if_we;
  logic [20:0] reg_if_addr;
  logic [15:0] reg_if_wdata;
  logic [15:0] reg_if_rdata = '0;
  logic        reg_if_ready = 1'b0;
  logic        timeout_pulse, grant_id;

  reg_if_arbiter #(.TIMEOUT_CYC(TO), .TIMEOUT_RDATA(TO_RD)) dut (
    .clk_25m(clk_25m), .rst(rst),
    .m0_valid(m0_valid), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_rdata(m0_rdata), .m0_ready(m0_ready),
    .m1_valid(m1_valid), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_rdata(m1_rdata), .m1_ready(m1_ready),
    .reg_if_valid(reg_if_valid), .reg_if_we(reg_if_we), .reg_if_addr(reg_if_addr),
    .reg_if_wdata(reg_if_wdata), .reg_if_rdata(reg_if_rdata), .reg_if_ready(reg_if_ready),
    .timeout_pulse(timeout_pulse), .grant_id(grant_id)
  );

  always #20 clk_25m = ~clk_25m;

  typedef struct { logic we; logic [20:0] addr; logic [15:0] wdata; } req_t;
  typedef struct { int d; logic [15:0] rdata; } plan_t;
  typedef struct {
    int id; logic we; logic [20:0] addr; logic [15:0] wdata;
    int vlen; bit lat; int gap;
  } tgt_t;
  typedef struct { logic [15:0] rdata; bit chk; bit to; } cmp_t;

  req_t  drv_q0[$], drv_q1[$];   // requests each requester still has to issue
  plan_t plan_q[$];              // target behaviour, in predicted grant order
  tgt_t  tgt_q[$];               // expected target transactions, grant order
  cmp_t  cmp_q0[$], cmp_q1[$];   // expected completions per requester

  int checks = 0, errors = 0;
  int cyc = 0;
  int req_cyc[2];
  int model_last = 1;
  bit mon_en = 1'b0;

  always @(posedge clk_25m) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: a transaction takes d+1 BUSY cycles unless that exceeds the
  // watchdog limit, in which case it lasts TO cycles and returns TO_RD.
  task automatic issue(input int id, input logic we, input logic [20:0] addr,
                       input logic [15:0] wdata, input int d, input logic [15:0] rd,
                       input bit lat, input int gap, input bit push_drv, input bit exp_cmp);
    bit    to = (d + 1 > TO);
    req_t  r;
    plan_t p;
    tgt_t  t;
    cmp_t  c;
    r = '{we, addr, wdata};
    p = '{d, rd};
    t = '{id, we, addr, wdata, exp_cmp ? (to ? TO : d + 1) : -1, lat, gap};
    c = '{to ? TO_RD : rd, !we, to};
    if (push_drv) begin
      if (id == 0) drv_q0.push_back(r); else drv_q1.push_back(r);
    end
    plan_q.push_back(p);
    tgt_q.push_back(t);
    if (exp_cmp) begin
      if (id == 0) cmp_q0.push_back(c); else cmp_q1.push_back(c);
    end
    model_last = id;
  endtask

  task automatic wait_drain(input int budget);
    int i = 0;
    while (i < budget && !(drv_q0.size() == 0 && drv_q1.size() == 0 && tgt_q.size() == 0 &&
                           cmp_q0.size() == 0 && cmp_q1.size() == 0 &&
                           !m0_valid && !m1_valid && !reg_if_valid)) begin
      @(negedge clk_25m);
      i++;
    end
    checks++;
    if (i >= budget) begin
      errors++;
      $display("FAIL drain: transactions outstanding after %0d cycles (tgt %0d cmp0 %0d cmp1 %0d)",
               budget, tgt_q.size(), cmp_q0.size(), cmp_q1.size());
      drv_q0.delete(); drv_q1.delete(); plan_q.delete();
      tgt_q.delete(); cmp_q0.delete(); cmp_q1.delete();
    end
    @(posedge clk_25m);
    #1;
  endtask

  // ---------------- requester drivers ----------------
  task automatic set_req(input int id, input logic v, input req_t r);
    if (id == 0) begin
      m0_valid = v; m0_we = r.we; m0_addr = r.addr; m0_wdata = r.wdata;
    end else begin
      m1_valid = v; m1_we = r.we; m1_addr = r.addr; m1_wdata = r.wdata;
    end
  endtask

  task automatic drive(input int id);
    req_t r;
    bit   busy = 1'b0;
    bit   have;
    forever begin
      @(negedge clk_25m);
      if (!busy) begin
        have = (id == 0) ? (drv_q0.size() > 0) : (drv_q1.size() > 0);
        if (have) begin
          if (id == 0) r = drv_q0.pop_front(); else r = drv_q1.pop_front();
          set_req(id, 1'b1, r);
          req_cyc[id] = cyc;
          busy = 1'b1;
        end
      end else if ((id == 0) ? m0_ready : m1_ready) begin
        // Change or drop the request only after the ready cycle has ended.
        @(posedge clk_25m);
        #1;
        have = (id == 0) ? (drv_q0.size() > 0) : (drv_q1.size() > 0);
        if (have) begin
          if (id == 0) r = drv_q0.pop_front(); else r = drv_q1.pop_front();
          set_req(id, 1'b1, r);
          req_cyc[id] = cyc;
        end else begin
          r = '{1'b0, 21'h0, 16'h0};
          set_req(id, 1'b0, r);
          busy = 1'b0;
        end
      end
    end
  endtask

  initial drive(0);
  initial drive(1);

  // ---------------- register-file target ----------------
  initial begin
    plan_t p;
    bit    active = 1'b0;
    int    cnt = 0;
    p = '{255, 16'h0};
    forever begin
      @(negedge clk_25m);
      if (reg_if_valid === 1'b1) begin
        if (!active) begin
          active = 1'b1;
          cnt = 0;
          if (plan_q.size() > 0) p = plan_q.pop_front(); else p = '{255, 16'h0};
        end
        if (cnt == p.d) begin
          reg_if_ready = 1'b1;
          reg_if_rdata = p.rdata;
        end else begin
          reg_if_ready = 1'b0;
          reg_if_rdata = 16'($urandom);
        end
        cnt++;
      end else begin
        // Stray acknowledges outside a transaction must be ignored.
        active = 1'b0;
        reg_if_ready = ($urandom_range(3) == 0);
        reg_if_rdata = 16'($urandom);
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  task automatic on_ready(input int id, input logic prev, input logic [15:0] rd, input logic other);
    cmp_t c;
    bit   empty = (id == 0) ? (cmp_q0.size() == 0) : (cmp_q1.size() == 0);
    check($sformatf("m%0d_ready_one_cycle", id), 32'(prev), 32'd0);
    check("ready_exclusive", 32'(other), 32'd0);
    check("grant_id_at_ready", 32'(grant_id), 32'(id));
    checks++;
    if (empty) begin
      errors++;
      $display("FAIL m%0d_ready: unexpected completion, rdata %0h", id, rd);
    end else begin
      if (id == 0) c = cmp_q0.pop_front(); else c = cmp_q1.pop_front();
      if (c.chk) check($sformatf("m%0d_rdata", id), 32'(rd), 32'(c.rdata));
      check("timeout_pulse", 32'(timeout_pulse), 32'(c.to));
    end
  endtask

  initial begin
    tgt_t e;
    logic prev_v = 1'b0, prev_r0 = 1'b0, prev_r1 = 1'b0;
    int   run = 0, cur_vlen = -1, last_gcyc = 0;
    forever begin
      @(negedge clk_25m);
      if (mon_en) begin
        if (reg_if_valid && !prev_v) begin
          checks++;
          if (tgt_q.size() == 0) begin
            errors++;
            $display("FAIL target_txn: unexpected request addr %0h", reg_if_addr);
            cur_vlen = -1;
          end else begin
            e = tgt_q.pop_front();
            check("reg_if_addr", 32'(reg_if_addr), 32'(e.addr));
            check("reg_if_we", 32'(reg_if_we), 32'(e.we));
            if (e.we) check("reg_if_wdata", 32'(reg_if_wdata), 32'(e.wdata));
            check("grant_id", 32'(grant_id), 32'(e.id));
            if (e.lat) check("req_to_target_latency", 32'(cyc - req_cyc[e.id]), 32'd1);
            if (e.gap >= 0) check("grant_spacing", 32'(cyc - last_gcyc), 32'(e.gap));
            cur_vlen = e.vlen;
          end
          last_gcyc = cyc;
          run = 0;
        end
        if (reg_if_valid) run++;
        if (!reg_if_valid && prev_v && cur_vlen >= 0)
          check("reg_if_valid_cycles", 32'(run), 32'(cur_vlen));
        if (m0_ready) on_ready(0, prev_r0, m0_rdata, m1_ready);
        if (m1_ready) on_ready(1, prev_r1, m1_rdata, m0_ready);
        if (timeout_pulse && !m0_ready && !m1_ready)
          check("timeout_without_ready", 32'(timeout_pulse), 32'd0);
      end
      prev_v  = reg_if_valid;
      prev_r0 = m0_ready;
      prev_r1 = m1_ready;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int first;
    repeat (3) @(posedge clk_25m);
    @(negedge clk_25m);
    check("rst_reg_if_valid", 32'(reg_if_valid), 32'd0);
    check("rst_reg_if_we", 32'(reg_if_we), 32'd0);
    check("rst_reg_if_addr", 32'(reg_if_addr), 32'd0);
    check("rst_reg_if_wdata", 32'(reg_if_wdata), 32'd0);
    check("rst_m0_rdata", 32'(m0_rdata), 32'd0);
    check("rst_m1_rdata", 32'(m1_rdata), 32'd0);
    check("rst_m0_ready", 32'(m0_ready), 32'd0);
    check("rst_m1_ready", 32'(m1_ready), 32'd0);
    check("rst_timeout_pulse", 32'(timeout_pulse), 32'd0);
    check("rst_grant_id", 32'(grant_id), 32'd1);
    rst = 1'b0;
    mon_en = 1'b1;
    model_last = 1;
    @(posedge clk_25m);
    #1;

    // Single read from requester 0, target answers in its second BUSY cycle.
    issue(0, 1'b0, 21'h01_0002, 16'h0, 1, 16'h1234, 1'b1, -1, 1'b1, 1'b1);
    wait_drain(40);

    // Single write from requester 1, zero-wait target.
    issue(1, 1'b1, 21'h00_001F, 16'hA5A5, 0, 16'h0, 1'b1, -1, 1'b1, 1'b1);
    wait_drain(40);

    // Contention, zero-wait: strict alternation, one grant every 3 cycles.
    first = model_last ^ 1;
    for (int i = 0; i < 3; i++) begin
      issue(first, 1'b0, 21'(16 + i), 16'h0, 0, 16'h1000 + 16'(i), 1'b0,
            (i == 0) ? -1 : 3, 1'b1, 1'b1);
      issue(first ^ 1, 1'b0, 21'(32 + i), 16'h0, 0, 16'h2000 + 16'(i), 1'b0,
            3, 1'b1, 1'b1);
    end
    wait_drain(80);

    // Watchdog: target never answers, then a normal request from requester 1.
    issue(0, 1'b0, 21'h0A_BCDE, 16'h0, 255, 16'h0, 1'b1, -1, 1'b1, 1'b1);
    wait_drain(60);
    issue(1, 1'b0, 21'h00_0100, 16'h0, 2, 16'hCAFE, 1'b1, -1, 1'b1, 1'b1);
    wait_drain(40);

    // Acknowledge in the very cycle the watchdog would fire: data wins.
    issue(0, 1'b0, 21'h1F_FFFF, 16'h0, TO - 1, 16'h0BEE, 1'b1, -1, 1'b1, 1'b1);
    wait_drain(60);

    // Randomized single-requester traffic, including timeouts.
    for (int i = 0; i < 40; i++) begin
      issue($urandom_range(1), 1'($urandom_range(1)), 21'($urandom), 16'($urandom),
            $urandom_range(10), 16'($urandom), 1'b1, -1, 1'b1, 1'b1);
      wait_drain(60);
    end

    // Randomized continuous contention.
    first = model_last ^ 1;
    for (int i = 0; i < 10; i++) begin
      issue(first, 1'($urandom_range(1)), 21'($urandom), 16'($urandom),
            $urandom_range(9), 16'($urandom), 1'b0, -1, 1'b1, 1'b1);
      issue(first ^ 1, 1'($urandom_range(1)), 21'($urandom), 16'($urandom),
            $urandom_range(9), 16'($urandom), 1'b0, -1, 1'b1, 1'b1);
    end
    wait_drain(400);

    // Reset while requester 1's transaction is in BUSY.
    issue(1, 1'b0, 21'h00_0777, 16'h0, 255, 16'h0, 1'b1, -1, 1'b1, 1'b0);
    for (int i = 0; i < 20 && !reg_if_valid; i++) @(negedge clk_25m);
    check("busy_before_reset", 32'(reg_if_valid), 32'd1);
    @(negedge clk_25m);
    @(negedge clk_25m);
    rst = 1'b1;
    model_last = 1;
    issue(0, 1'b0, 21'h00_0555, 16'h0, 1, 16'h5A5A, 1'b0, -1, 1'b1, 1'b1);
    issue(1, 1'b0, 21'h00_0777, 16'h0, 0, 16'h7777, 1'b0, -1, 1'b0, 1'b1);
    @(negedge clk_25m);
    check("midrst_reg_if_valid", 32'(reg_if_valid), 32'd0);
    check("midrst_reg_if_addr", 32'(reg_if_addr), 32'd0);
    check("midrst_m1_ready", 32'(m1_ready), 32'd0);
    check("midrst_m1_rdata", 32'(m1_rdata), 32'd0);
    check("midrst_timeout_pulse", 32'(timeout_pulse), 32'd0);
    check("midrst_grant_id", 32'(grant_id), 32'd1);
    rst = 1'b0;
    wait_drain(60);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Absolute guard so the run always ends.
  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "global timeout");
  end

endmodule
